// File: rtl/pixel_cursor_pkg.sv
// Shared types and helpers for the pixel cursor controller.
package pixel_cursor_pkg;

  // Widest row_select vector the index helper accepts.
  localparam int unsigned SEL_W = 32;

  // Hold-to-repeat state of one axis.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REPEAT
  } rpt_state_t;

  // Requested step direction of one axis.
  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_INC,
    DIR_DEC
  } step_dir_t;

  // Index of the highest set bit; 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(input logic [SEL_W-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < SEL_W; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage : pixel_cursor_pkg

// File: rtl/pixel_cursor_ctrl_axis_repeat.sv
// One cursor axis: resolves inc/dec button levels into a direction and
// produces a single-cycle step strobe with hold-to-repeat timing.
module axis_repeat
  import pixel_cursor_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_inc,
  input  logic      i_dec,
  input  logic      i_clear,
  output logic      o_step,
  output step_dir_t o_dir
);

  localparam int unsigned CNT_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);

  rpt_state_t    r_state;
  step_dir_t     r_dir;
  logic [CW-1:0] r_cnt;

  step_dir_t     w_dir;
  logic          w_hold;
  logic          w_step;

  // Resolve the two button levels; both or neither pressed means no direction.
  always_comb begin
    w_dir = DIR_NONE;
    if (i_inc && !i_dec)      w_dir = DIR_INC;
    else if (i_dec && !i_inc) w_dir = DIR_DEC;
  end

  // Step strobe is combinational so the position register moves on the same
  // edge that samples the button; an idle FSM treats any held level as a fresh
  // press, which covers reset-while-held and direction changes.
  always_comb begin
    w_hold = (w_dir == r_dir);
    w_step = 1'b0;
    if (!i_clear && (w_dir != DIR_NONE)) begin
      unique case (r_state)
        ST_IDLE:   w_step = 1'b1;
        ST_WAIT:   w_step = w_hold && (r_cnt == DLY_LAST);
        ST_REPEAT: w_step = w_hold && (r_cnt == RATE_LAST);
        default:   w_step = 1'b0;
      endcase
    end
  end

  assign o_step = w_step;
  assign o_dir  = w_dir;

  // Repeat FSM: delay before the first repeat, then a fixed repeat rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_NONE;
      r_cnt   <= '0;
    end else if (i_clear || (w_dir == DIR_NONE)) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_NONE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_state <= ST_WAIT;
          r_dir   <= w_dir;
          r_cnt   <= '0;
        end
        ST_WAIT: begin
          if (!w_hold) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_NONE;
            r_cnt   <= '0;
          end else if (r_cnt == DLY_LAST) begin
            r_state <= ST_REPEAT;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        ST_REPEAT: begin
          if (!w_hold) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_NONE;
            r_cnt   <= '0;
          end else if (r_cnt == RATE_LAST) begin
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_dir   <= DIR_NONE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule : axis_repeat

// File: rtl/pixel_cursor_ctrl.sv
// Cursor position controller for the LED-matrix grid: x from left/right,
// y from up/down or a one-hot row pick, with wrap or saturate at the edges.
// Optional blink output enabled by defining CURSOR_BLINK_EN.
module pixel_cursor_ctrl
  import pixel_cursor_pkg::*;
#(
  parameter int unsigned COLS         = 8,
  parameter int unsigned ROWS         = 8,
  parameter int unsigned WRAP         = 1,
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_RATE  = 4,
  parameter int unsigned BLINK_PERIOD = 32,
  localparam int unsigned XW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned YW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            left,
  input  logic            right,
  input  logic            up,
  input  logic            down,
  input  logic [ROWS-1:0] row_select,
  output logic [XW-1:0]   cur_x,
  output logic [YW-1:0]   cur_y,
  output logic            moved,
  output logic            cursor_on
);

  localparam logic [XW:0] X_LAST = (XW + 1)'(COLS - 1);
  localparam logic [YW:0] Y_LAST = (YW + 1)'(ROWS - 1);

  if (COLS < 2 || ROWS < 2 || ROWS > SEL_W || REPEAT_DELAY < 1 ||
      REPEAT_RATE < 1 || BLINK_PERIOD < 1) begin : g_bad_params
    $error("pixel_cursor_ctrl: illegal parameter set");
  end

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_chg;
  logic          r_moved;

  logic          w_step_x;
  logic          w_step_y;
  step_dir_t     w_dir_x;
  step_dir_t     w_dir_y;
  logic          w_row_pick;
  logic [XW:0]   w_x_ext;
  logic [YW:0]   w_y_ext;
  logic [XW:0]   w_x_nxt_ext;
  logic [YW:0]   w_y_nxt_ext;
  logic [XW-1:0] w_x_next;
  logic [YW-1:0] w_y_next;
  logic          w_chg;

  assign w_row_pick = |row_select;

  axis_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_axis_x (
    .clk     (clk),
    .rst_n   (reset),
    .i_inc   (left),
    .i_dec   (right),
    .i_clear (1'b0),
    .o_step  (w_step_x),
    .o_dir   (w_dir_x)
  );

  axis_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_axis_y (
    .clk     (clk),
    .rst_n   (reset),
    .i_inc   (up),
    .i_dec   (down),
    .i_clear (w_row_pick),
    .o_step  (w_step_y),
    .o_dir   (w_dir_y)
  );

  // Next x: one-bit-wider arithmetic so edge tests work for any COLS.
  always_comb begin
    w_x_ext     = {1'b0, r_x};
    w_x_nxt_ext = w_x_ext;
    if (w_step_x && (w_dir_x == DIR_INC)) begin
      if (w_x_ext == X_LAST) w_x_nxt_ext = (WRAP != 0) ? '0 : w_x_ext;
      else                   w_x_nxt_ext = w_x_ext + (XW + 1)'(1);
    end else if (w_step_x && (w_dir_x == DIR_DEC)) begin
      if (w_x_ext == '0)     w_x_nxt_ext = (WRAP != 0) ? X_LAST : '0;
      else                   w_x_nxt_ext = w_x_ext - (XW + 1)'(1);
    end
    w_x_next = w_x_nxt_ext[XW-1:0];
  end

  // Next y: a row pick overrides any up/down step in the same cycle.
  always_comb begin
    w_y_ext     = {1'b0, r_y};
    w_y_nxt_ext = w_y_ext;
    if (w_row_pick) begin
      w_y_nxt_ext = (YW + 1)'(onehot_to_idx(SEL_W'(row_select)));
    end else if (w_step_y && (w_dir_y == DIR_INC)) begin
      if (w_y_ext == Y_LAST) w_y_nxt_ext = (WRAP != 0) ? '0 : w_y_ext;
      else                   w_y_nxt_ext = w_y_ext + (YW + 1)'(1);
    end else if (w_step_y && (w_dir_y == DIR_DEC)) begin
      if (w_y_ext == '0)     w_y_nxt_ext = (WRAP != 0) ? Y_LAST : '0;
      else                   w_y_nxt_ext = w_y_ext - (YW + 1)'(1);
    end
    w_y_next = w_y_nxt_ext[YW-1:0];
  end

  assign w_chg = (w_x_next != r_x) || (w_y_next != r_y);

  // Position registers; moved trails the position change by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_chg   <= 1'b0;
      r_moved <= 1'b0;
    end else begin
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_chg   <= w_chg;
      r_moved <= r_chg;
    end
  end

  assign cur_x = r_x;
  assign cur_y = r_y;
  assign moved = r_moved;

`ifdef CURSOR_BLINK_EN
  localparam int unsigned BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_PERIOD - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_on;

  // Blink timer; any position change shows the cursor and restarts the phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blink_cnt <= '0;
      r_on        <= 1'b1;
    end else if (w_chg) begin
      r_blink_cnt <= '0;
      r_on        <= 1'b1;
    end else if (r_blink_cnt == B_LAST) begin
      r_blink_cnt <= '0;
      r_on        <= ~r_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  assign cursor_on = r_on;
`else
  assign cursor_on = 1'b1;
`endif

endmodule : pixel_cursor_ctrl

// File: tb/tb_pixel_cursor_ctrl.sv
// Scoreboard bench: two cursor instances (8x8 wrapping, 6x5 saturating)
// share one set of buttons; a hold-count model predicts each edge's result.
module tb_pixel_cursor_ctrl;

  localparam int unsigned DLY   = 4;
  localparam int unsigned RATE  = 2;
  localparam int unsigned BLINK = 4;

  typedef struct {
    int u;
    int x;
    int y;
    int mv;
    int on;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       left, right, up, down;
  logic [7:0] row_sel;
  logic [2:0] a_x, a_y, b_x, b_y;
  logic       a_moved, a_on, b_moved, b_on;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb_q[$];

  int cols[2] = '{8, 6};
  int rows[2] = '{8, 5};
  int wrap[2] = '{1, 0};

  int mx[2], my[2], dx[2], hx[2], dy[2], hy[2], chg[2], bt[2];

  pixel_cursor_ctrl #(
    .COLS(8), .ROWS(8), .WRAP(1),
    .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .BLINK_PERIOD(BLINK)
  ) u_dut_a (
    .clk(clk), .reset(rst_n), .left(left), .right(right), .up(up), .down(down),
    .row_select(row_sel), .cur_x(a_x), .cur_y(a_y), .moved(a_moved), .cursor_on(a_on)
  );

  pixel_cursor_ctrl #(
    .COLS(6), .ROWS(5), .WRAP(0),
    .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .BLINK_PERIOD(BLINK)
  ) u_dut_b (
    .clk(clk), .reset(rst_n), .left(left), .right(right), .up(up), .down(down),
    .row_select(row_sel[4:0]), .cur_x(b_x), .cur_y(b_y), .moved(b_moved), .cursor_on(b_on)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int hi_idx(input int v);
    for (int i = 31; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  // Axis model in hold-count form: step on the first held cycle, then at
  // DLY, DLY+RATE, DLY+2*RATE ... cycles into the hold.
  task automatic axis(input int d_in, input int h_in, input int w, input bit clr,
                      output int d_o, output int h_o, output int st);
    st = 0;
    if (clr || w == 0) begin
      d_o = 0; h_o = 0;
    end else if (d_in == 0) begin
      st = w; d_o = w; h_o = 1;
    end else if (w != d_in) begin
      d_o = 0; h_o = 0;
    end else begin
      if (h_in >= int'(DLY) && ((h_in - int'(DLY)) % int'(RATE)) == 0) st = w;
      d_o = d_in; h_o = h_in + 1;
    end
  endtask

  function automatic int apply(input int v, input int s, input int n, input int wr);
    if (s == 1)  return (v == n - 1) ? (wr != 0 ? 0 : v) : v + 1;
    if (s == -1) return (v == 0) ? (wr != 0 ? n - 1 : 0) : v - 1;
    return v;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      mx[u] = 0; my[u] = 0; dx[u] = 0; hx[u] = 0;
      dy[u] = 0; hy[u] = 0; chg[u] = 0; bt[u] = 0;
    end
  endtask

  task automatic cycle(input bit l, input bit r, input bit up_i, input bit dn_i,
                       input logic [7:0] rs, input string tag);
    exp_t e;
    int wx, wy, sx, sy, nx, ny, rsm, c;
    left = l; right = r; up = up_i; down = dn_i; row_sel = rs;
    wx = (l && !r) ? 1 : ((r && !l) ? -1 : 0);
    wy = (up_i && !dn_i) ? 1 : ((dn_i && !up_i) ? -1 : 0);
    for (int u = 0; u < 2; u++) begin
      axis(dx[u], hx[u], wx, 1'b0, dx[u], hx[u], sx);
      nx  = apply(mx[u], sx, cols[u], wrap[u]);
      rsm = (u == 0) ? int'(rs) : int'(rs & 8'h1f);
      if (rsm != 0) begin
        axis(dy[u], hy[u], wy, 1'b1, dy[u], hy[u], sy);
        ny = hi_idx(rsm);
      end else begin
        axis(dy[u], hy[u], wy, 1'b0, dy[u], hy[u], sy);
        ny = apply(my[u], sy, rows[u], wrap[u]);
      end
      c = (nx != mx[u] || ny != my[u]) ? 1 : 0;
      if (c != 0) bt[u] = 0;
      else        bt[u] = bt[u] + 1;
      e.u  = u;
      e.x  = nx;
      e.y  = ny;
      e.mv = chg[u];
`ifdef CURSOR_BLINK_EN
      e.on = ((bt[u] / int'(BLINK)) % 2 == 0) ? 1 : 0;
`else
      e.on = 1;
`endif
      sb_q.push_back(e);
      chg[u] = c; mx[u] = nx; my[u] = ny;
    end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.u == 0) begin
        check_val({tag, ".a.x"},  a_x,     e.x);
        check_val({tag, ".a.y"},  a_y,     e.y);
        check_val({tag, ".a.mv"}, a_moved, e.mv);
        check_val({tag, ".a.on"}, a_on,    e.on);
      end else begin
        check_val({tag, ".b.x"},  b_x,     e.x);
        check_val({tag, ".b.y"},  b_y,     e.y);
        check_val({tag, ".b.mv"}, b_moved, e.mv);
        check_val({tag, ".b.on"}, b_on,    e.on);
      end
    end
  endtask

  // Reset asserted between edges while buttons stay as they are.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check_val("rst.a.x", a_x, 0);      check_val("rst.a.y", a_y, 0);
    check_val("rst.a.mv", a_moved, 0); check_val("rst.a.on", a_on, 1);
    check_val("rst.b.x", b_x, 0);      check_val("rst.b.y", b_y, 0);
    check_val("rst.b.mv", b_moved, 0); check_val("rst.b.on", b_on, 1);
    model_reset();
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit rl, rr, ru, rd;
    logic [7:0] rrs;
    rst_n = 1'b0;
    left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0; row_sel = '0;
    model_reset();
    #7;
    check_val("init.a.x", a_x, 0);  check_val("init.a.y", a_y, 0);
    check_val("init.a.mv", a_moved, 0); check_val("init.a.on", a_on, 1);
    check_val("init.b.x", b_x, 0);  check_val("init.b.y", b_y, 0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (12) cycle(1, 0, 0, 0, 8'h00, "hold_left");
    mid_reset();
    cycle(1, 0, 0, 0, 8'h00, "post_rst");
    repeat (3) cycle(1, 1, 0, 0, 8'h00, "both_lr");
    cycle(0, 0, 0, 0, 8'h00, "release");

    repeat (6) begin
      cycle(1, 0, 0, 0, 8'h00, "tap_left");
      cycle(0, 0, 0, 0, 8'h00, "tap_gap");
    end
    cycle(1, 0, 0, 0, 8'h00, "edge_left");
    cycle(0, 0, 0, 0, 8'h00, "edge_gap");
    cycle(0, 0, 0, 0, 8'h00, "edge_gap2");
    cycle(0, 1, 0, 0, 8'h00, "edge_right");
    cycle(0, 0, 0, 0, 8'h00, "edge_gap3");
    cycle(0, 0, 0, 0, 8'h00, "edge_gap4");

    repeat (2) cycle(0, 0, 1, 0, 8'h00, "up_hold");
    cycle(0, 0, 1, 0, 8'b0010_0100, "row_pick");
    cycle(0, 0, 1, 0, 8'h00, "row_rel");
    cycle(0, 0, 0, 0, 8'h00, "row_gap");
    cycle(0, 0, 0, 0, 8'b1000_0001, "row_multi");
    repeat (20) cycle(0, 0, 0, 1, 8'h00, "down_hold");
    cycle(0, 1, 0, 1, 8'h00, "dir_mix");
    repeat (3) cycle(1, 0, 0, 1, 8'h00, "dir_flip");

    rl = 0; rr = 0; ru = 0; rd = 0; rrs = '0;
    repeat (250) begin
      if ($urandom_range(0, 3) == 0) rl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ru = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rd = 1'($urandom_range(0, 1));
      rrs = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      cycle(rl, rr, ru, rd, rrs, "rand");
    end

    repeat (12) cycle(0, 0, 0, 0, 8'h00, "idle_blink");
    cycle(0, 1, 0, 0, 8'h00, "blink_move");
    repeat (6) cycle(0, 0, 0, 0, 8'h00, "blink_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pixel_cursor_ctrl
